// File: rtl/nibble_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_frame_sync
//  Description : Hunts for a sync nibble in a 4-bit sliding window, confirms
//                frame alignment over repeated frames, then emits payload
//                nibbles with a strobe and index. Isolated sync losses are
//                bridged by a flywheel; persistent losses drop lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_frame_sync #(
    parameter logic [3:0] SYNC_WORD = 4'b0110,
    parameter int         PAY_NIB   = 3,
    parameter int         LOCK_CNT  = 2,
    parameter int         MISS_CNT  = 2,
    localparam int        IDX_W     = (PAY_NIB > 1) ? $clog2(PAY_NIB) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       win,
    input  logic             win_valid,
    output logic [3:0]       data_out,
    output logic             data_valid,
    output logic [IDX_W-1:0] nib_idx,
    output logic             locked,
    output logic             sync_hit,
    output logic             sync_miss
);

    // Frame period in bits: one sync nibble plus the payload nibbles.
    localparam int FRAME_BITS = 4 * (PAY_NIB + 1);
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int HIT_W      = $clog2(LOCK_CNT + 1);
    localparam int MIS_W      = $clog2(MISS_CNT + 1);

    localparam logic [POS_W-1:0] c_pos_last = POS_W'(FRAME_BITS - 1);
    localparam logic [HIT_W-1:0] c_lock_cnt = HIT_W'(LOCK_CNT);
    localparam logic [MIS_W-1:0] c_miss_cnt = MIS_W'(MISS_CNT);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_nxt, w_cur;
    logic [HIT_W-1:0]   r_hit_cnt, w_hit_nxt, w_hit_inc;
    logic [MIS_W-1:0]   r_miss_cnt, w_miss_nxt, w_miss_inc;
    logic [3:0]         r_data_out, w_data_nxt;
    logic [IDX_W-1:0]   r_nib_idx, w_idx_nxt, w_cur_idx;
    logic [POS_W-3:0]   w_quad;
    logic               r_data_valid, w_dv_nxt;
    logic               r_locked, w_locked_nxt;
    logic               r_sync_hit, w_hit_pulse;
    logic               r_sync_miss, w_miss_pulse;
    logic               w_frame_bnd, w_nib_bnd, w_sync_match;

    // Position the current bit would take if the frame counter advances.
    assign w_cur        = (r_pos == c_pos_last) ? '0 : r_pos + 1'b1;
    assign w_frame_bnd  = (w_cur == '0);
    assign w_nib_bnd    = (w_cur[1:0] == 2'b00) && !w_frame_bnd;
    assign w_quad       = w_cur[POS_W-1:2];
    assign w_cur_idx    = IDX_W'(w_quad - 1'b1);
    assign w_sync_match = (win == SYNC_WORD);
    assign w_hit_inc    = r_hit_cnt + 1'b1;
    assign w_miss_inc   = r_miss_cnt + 1'b1;

    // Next-state, counter and output decisions; everything holds unless a new bit arrived.
    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_hit_nxt    = r_hit_cnt;
        w_miss_nxt   = r_miss_cnt;
        w_data_nxt   = r_data_out;
        w_idx_nxt    = r_nib_idx;
        w_dv_nxt     = 1'b0;
        w_hit_pulse  = 1'b0;
        w_miss_pulse = 1'b0;
        if (win_valid) begin
            case (r_state)
                S_HUNT: begin
                    // First detection anchors the frame and counts as the first hit.
                    if (w_sync_match) begin
                        w_pos_nxt   = '0;
                        w_hit_nxt   = HIT_W'(1);
                        w_miss_nxt  = '0;
                        w_state_nxt = (LOCK_CNT == 1) ? S_LOCKED : S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    w_pos_nxt = w_cur;
                    if (w_frame_bnd) begin
                        if (w_sync_match) begin
                            w_hit_pulse = 1'b1;
                            w_hit_nxt   = w_hit_inc;
                            if (w_hit_inc == c_lock_cnt) begin
                                w_state_nxt = S_LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            // Alignment was a false start; resume hunting on the next bit.
                            w_state_nxt = S_HUNT;
                            w_hit_nxt   = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    w_pos_nxt = w_cur;
                    if (w_nib_bnd) begin
                        w_data_nxt = win;
                        w_idx_nxt  = w_cur_idx;
                        w_dv_nxt   = 1'b1;
                    end else if (w_frame_bnd) begin
                        if (w_sync_match) begin
                            w_hit_pulse = 1'b1;
                            w_miss_nxt  = '0;
                        end else begin
                            w_miss_pulse = 1'b1;
                            if (w_miss_inc == c_miss_cnt) begin
                                w_state_nxt = S_HUNT;
                                w_hit_nxt   = '0;
                                w_miss_nxt  = '0;
                            end else begin
                                w_miss_nxt = w_miss_inc;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_HUNT;
                    w_hit_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    assign w_locked_nxt = (w_state_nxt == S_LOCKED);

    // State, counters and registered outputs; reset clears all of them at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HUNT;
            r_pos        <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_data_out   <= '0;
            r_nib_idx    <= '0;
            r_data_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_hit   <= 1'b0;
            r_sync_miss  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_hit_cnt    <= w_hit_nxt;
            r_miss_cnt   <= w_miss_nxt;
            r_data_out   <= w_data_nxt;
            r_nib_idx    <= w_idx_nxt;
            r_data_valid <= w_dv_nxt;
            r_locked     <= w_locked_nxt;
            r_sync_hit   <= w_hit_pulse;
            r_sync_miss  <= w_miss_pulse;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign nib_idx    = r_nib_idx;
    assign locked     = r_locked;
    assign sync_hit   = r_sync_hit;
    assign sync_miss  = r_sync_miss;

endmodule
`default_nettype wire

// File: tb/tb_nibble_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_frame_sync
//  Description : Self-checking bench for nibble_frame_sync with a bit-stream
//                shift-register model and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_frame_sync;

    localparam logic [3:0] SYNC     = 4'b0110;
    localparam int         PAY_NIB  = 3;
    localparam int         LOCK_CNT = 2;
    localparam int         MISS_CNT = 2;
    localparam int         P        = 4 * (PAY_NIB + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] win = 4'b0;
    logic       win_valid = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic [1:0] nib_idx;
    logic       locked;
    logic       sync_hit;
    logic       sync_miss;

    int n_checks = 0;
    int n_errors = 0;

    nibble_frame_sync #(
        .SYNC_WORD (SYNC),
        .PAY_NIB   (PAY_NIB),
        .LOCK_CNT  (LOCK_CNT),
        .MISS_CNT  (MISS_CNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .win        (win),
        .win_valid  (win_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .nib_idx    (nib_idx),
        .locked     (locked),
        .sync_hit   (sync_hit),
        .sync_miss  (sync_miss)
    );

    always #5 clk = ~clk;

    // Upstream shift register contents and queued bit stream.
    logic [3:0] sr = 4'b0;
    bit         bq[$];

    // Reference model: mode 0 hunting, 1 confirming, 2 locked.
    int         m_mode, m_bits, m_hits, m_misses;
    logic [3:0] e_data;
    int         e_idx;
    bit         e_dv, e_lock, e_hit, e_miss;

    function automatic void model_reset();
        m_mode = 0; m_bits = 0; m_hits = 0; m_misses = 0;
        e_data = 4'h0; e_idx = 0;
        e_dv = 0; e_lock = 0; e_hit = 0; e_miss = 0;
    endfunction

    function automatic void model_step(bit v, logic [3:0] w);
        e_dv = 0; e_hit = 0; e_miss = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (w == SYNC) begin
                    m_bits = 0; m_hits = 1; m_misses = 0;
                    m_mode = (LOCK_CNT == 1) ? 2 : 1;
                end
            end else begin
                m_bits = (m_bits + 1) % P;
                if (m_bits == 0) begin
                    if (w == SYNC) begin
                        e_hit = 1;
                        if (m_mode == 1) begin
                            m_hits++;
                            if (m_hits >= LOCK_CNT) begin m_mode = 2; m_misses = 0; end
                        end else begin
                            m_misses = 0;
                        end
                    end else if (m_mode == 1) begin
                        m_mode = 0; m_hits = 0;
                    end else begin
                        e_miss = 1;
                        m_misses++;
                        if (m_misses >= MISS_CNT) begin m_mode = 0; m_hits = 0; m_misses = 0; end
                    end
                end else if (m_mode == 2 && (m_bits % 4) == 0) begin
                    e_dv = 1; e_data = w; e_idx = m_bits / 4 - 1;
                end
            end
        end
        e_lock = (m_mode == 2);
    endfunction

    function automatic logic [9:0] dut_vec();
        return {data_valid, locked, sync_hit, sync_miss, data_out, nib_idx};
    endfunction

    function automatic logic [9:0] exp_vec();
        return {e_dv, e_lock, e_hit, e_miss, e_data, 2'(e_idx)};
    endfunction

    task automatic send_bit(input bit b);
        sr = {sr[2:0], b};
        win = sr;
        win_valid = 1'b1;
        model_step(1'b1, sr);
        @(posedge clk);
        #1;
    endtask

    task automatic send_idle();
        win_valid = 1'b0;
        win = 4'bxxxx;
        model_step(1'b0, 4'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic add_nib(input logic [3:0] n);
        for (int k = 3; k >= 0; k--) bq.push_back(n[k]);
    endtask

    task automatic add_frame(input logic [3:0] s);
        add_nib(s); add_nib(4'hA); add_nib(4'h5); add_nib(4'hC);
    endtask

    task automatic pulse_reset();
        win_valid = 1'b0;
        reset = 1'b0;
        sr = 4'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; win_valid = 1'b0; win = 4'b0; sr = 4'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_state: dut=%b expected=%b", dut_vec(), 10'b0);
        end
        win = 4'bxxxx;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        n_checks++;
        if (dut_vec() !== 10'b0) begin
            n_errors++;
            $display("FAIL idle_after_release: dut=%b expected=%b", dut_vec(), 10'b0);
        end
    endtask

    task automatic test_lock();
        int first_hit = -1, first_lock = -1, hits = 0;
        logic [3:0] dq[$];
        int iq[$];
        logic [3:0] exp_nib;
        bq.delete();
        repeat (3) add_frame(SYNC);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL lock_bit[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
            if (sync_hit === 1'b1) begin hits++; if (first_hit < 0) first_hit = i; end
            if (locked === 1'b1 && first_lock < 0) first_lock = i;
            if (data_valid === 1'b1) begin dq.push_back(data_out); iq.push_back(int'(nib_idx)); end
        end
        n_checks++;
        if (first_hit != 19 || first_lock != 19) begin
            n_errors++;
            $display("FAIL lock_timing: hit_at=%0d lock_at=%0d expected 19/19", first_hit, first_lock);
        end
        n_checks++;
        if (hits != 2) begin
            n_errors++;
            $display("FAIL lock_hits: got %0d expected 2", hits);
        end
        n_checks++;
        if (dq.size() != 6) begin
            n_errors++;
            $display("FAIL lock_payload_count: got %0d expected 6", dq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_nib = (k % 3 == 0) ? 4'hA : (k % 3 == 1) ? 4'h5 : 4'hC;
                n_checks++;
                if (dq[k] !== exp_nib || iq[k] != k % 3) begin
                    n_errors++;
                    $display("FAIL lock_payload[%0d]: got %h/%0d expected %h/%0d", k, dq[k], iq[k], exp_nib, k % 3);
                end
            end
        end
    endtask

    task automatic test_flywheel();
        int misses = 0, hits = 0, dvs = 0, low = 0, miss_at = -1, hit_at = -1;
        bq.delete();
        add_frame(4'b0111);
        add_frame(SYNC);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL flywheel_bit[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
            if (sync_miss === 1'b1) begin misses++; miss_at = i; end
            if (sync_hit === 1'b1) begin hits++; hit_at = i; end
            if (data_valid === 1'b1) dvs++;
            if (locked !== 1'b1) low++;
        end
        n_checks++;
        if (misses != 1 || miss_at != 3 || hits != 1 || hit_at != 19) begin
            n_errors++;
            $display("FAIL flywheel_sync: miss=%0d@%0d hit=%0d@%0d expected 1@3 1@19", misses, miss_at, hits, hit_at);
        end
        n_checks++;
        if (low != 0 || dvs != 6) begin
            n_errors++;
            $display("FAIL flywheel_hold: unlocked_cycles=%0d payload=%0d expected 0 and 6", low, dvs);
        end
    endtask

    task automatic test_drop();
        int misses = 0, dv_a = 0, dv_b = 0, dv_c = 0, relock = -1;
        logic lk18 = 1'b0, lk19 = 1'b1, mi19 = 1'b0;
        bq.delete();
        add_frame(4'b0000);
        add_frame(4'b0000);
        add_frame(SYNC);
        add_frame(SYNC);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL drop_bit[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
            if (sync_miss === 1'b1) misses++;
            if (i == 18) lk18 = locked;
            if (i == 19) begin lk19 = locked; mi19 = sync_miss; end
            if (data_valid === 1'b1) begin
                if (i <= 18) dv_a++; else if (i <= 51) dv_b++; else dv_c++;
            end
            if (i > 19 && locked === 1'b1 && relock < 0) relock = i;
        end
        n_checks++;
        if (misses != 2 || lk18 !== 1'b1 || lk19 !== 1'b0 || mi19 !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_lock: misses=%0d lk18=%b lk19=%b miss19=%b expected 2 1 0 1", misses, lk18, lk19, mi19);
        end
        n_checks++;
        if (dv_a != 3 || dv_b != 0 || dv_c != 3 || relock != 51) begin
            n_errors++;
            $display("FAIL drop_payload: %0d/%0d/%0d relock=%0d expected 3/0/3 relock=51", dv_a, dv_b, dv_c, relock);
        end
    endtask

    task automatic test_confirm_abort();
        int pulses = 0, lk = 0;
        pulse_reset();
        bq.delete();
        add_nib(SYNC); add_nib(4'h0); add_nib(4'h0); add_nib(4'h0);
        add_nib(4'b1001); add_nib(4'h0); add_nib(4'h0);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL abort_bit[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
            if (sync_hit === 1'b1 || sync_miss === 1'b1 || data_valid === 1'b1) pulses++;
            if (locked !== 1'b0) lk++;
        end
        n_checks++;
        if (pulses != 0 || lk != 0) begin
            n_errors++;
            $display("FAIL abort_quiet: pulses=%0d locked_cycles=%0d expected 0 and 0", pulses, lk);
        end
    endtask

    task automatic test_stall();
        int hit_at = -1;
        logic [3:0] dq[$];
        int iq[$];
        bq.delete();
        add_frame(SYNC);
        add_nib(SYNC); add_nib(4'hA);
        bq.push_back(1'b0); bq.push_back(1'b1);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL stall_pre[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
        end
        for (int k = 0; k < 5; k++) begin
            send_idle();
            n_checks++;
            if (dut_vec() !== {1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 2'd0} || dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: dut=%b expected=%b", k, dut_vec(), exp_vec());
            end
        end
        bq.delete();
        bq.push_back(1'b0); bq.push_back(1'b1);
        add_nib(4'hC); add_nib(SYNC);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL stall_post[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
            if (data_valid === 1'b1) begin dq.push_back(data_out); iq.push_back(int'(nib_idx)); end
            if (sync_hit === 1'b1) hit_at = i;
        end
        n_checks++;
        if (dq.size() != 2 || dq[0] !== 4'h5 || dq[1] !== 4'hC || iq[0] != 1 || iq[1] != 2 || hit_at != 9) begin
            n_errors++;
            $display("FAIL stall_resume: count=%0d hit_at=%0d expected 5/1 C/2 hit_at=9", dq.size(), hit_at);
        end
    endtask

    task automatic test_async_reset();
        logic dv_before;
        int lock_at = -1, dvs = 0;
        bq.delete();
        add_nib(4'hA);
        foreach (bq[i]) send_bit(bq[i]);
        dv_before = data_valid;
        n_checks++;
        if (dv_before !== 1'b1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_setup: data_valid=%b locked=%b expected 1 1", dv_before, locked);
        end
        reset = 1'b0;
        win_valid = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 10'b0) begin
            n_errors++;
            $display("FAIL areset_immediate: dut=%b expected=%b", dut_vec(), 10'b0);
        end
        sr = 4'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bq.delete();
        add_frame(SYNC);
        add_frame(SYNC);
        foreach (bq[i]) begin
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL areset_bit[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
            if (locked === 1'b1 && lock_at < 0) lock_at = i;
            if (data_valid === 1'b1) dvs++;
        end
        n_checks++;
        if (lock_at != 19 || dvs != 3) begin
            n_errors++;
            $display("FAIL areset_relock: lock_at=%0d payload=%0d expected 19 and 3", lock_at, dvs);
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        bq.delete();
        repeat ($urandom_range(0, 3)) bq.push_back(1'($urandom_range(0, 1)));
        for (int f = 0; f < 24; f++) begin
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : SYNC;
            add_nib(s);
            for (int n = 0; n < PAY_NIB; n++) add_nib(4'($urandom));
        end
        foreach (bq[i]) begin
            if ($urandom_range(0, 7) == 0) begin
                send_idle();
                n_checks++;
                if (dut_vec() !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL random_idle[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
                end
            end
            send_bit(bq[i]);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_bit[%0d]: dut=%b expected=%b", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flywheel();
        test_drop();
        test_confirm_abort();
        test_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_frame_sync.md
Name: nibble_frame_sync

Overview:
- Downstream consumer of the 4-bit serial shift register.
- Watches the parallel window that register produces each bit time, hunts for a sync nibble, and confirms frame alignment over repeated frames.
- Once locked, emits the payload nibbles with a valid strobe and an index.
- Tolerates isolated sync corruption (flywheel) and drops lock after persistent misses.

Parameters:
- SYNC_WORD, 4'b0110: sync nibble marking the end of each frame header.
- PAY_NIB, 3: payload nibbles per frame (>=1). Frame period P = 4*(PAY_NIB+1) bits.
- LOCK_CNT, 2: consecutive sync hits, including the first detection, needed to lock (>=1).
- MISS_CNT, 2: consecutive sync misses while locked that drop lock (>=1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- win  in  4  shift-register window; win[3] oldest bit, win[0] newest.
- win_valid  in  1  1 = win shifted in a new bit this cycle ("valid cycle"); tie high for one bit per clock.
- data_out  out  4  last payload nibble (equals win at its nibble boundary).
- data_valid  out  1  one-clock pulse; data_out/nib_idx are new.
- nib_idx  out  max(1,clog2(PAY_NIB))  payload nibble index 0..PAY_NIB-1.
- locked  out  1  level; FSM in LOCKED.
- sync_hit  out  1  one-clock pulse; sync checked at a frame boundary and matched (CONFIRM/LOCKED only).
- sync_miss  out  1  one-clock pulse; sync checked at a frame boundary while LOCKED and mismatched.

Behaviour:
- Reset: state=HUNT, pos=0, hit/miss counters=0. All outputs 0 asynchronously.
- Non-valid cycles: FSM, pos and counters hold; pulses deassert; data_out, nib_idx and locked hold.
- pos width clog2(P). On each valid cycle outside HUNT, cur = (pos+1) mod P; pos<=cur.
  - Frame boundary: cur==0.
  - Nibble boundary: cur[1:0]==0 and cur!=0; nibble index = cur/4 - 1.
- All outputs are registered: they reflect the valid cycle one clock later.
- HUNT:
  - Valid cycle with win==SYNC_WORD: pos<=0, hit_cnt<=1.
  - Go to LOCKED if LOCK_CNT==1, else CONFIRM.
  - Any other window: stay. No output pulses are generated in HUNT.
- CONFIRM:
  - Frame boundary, win==SYNC_WORD: sync_hit pulse, hit_cnt+1. On reaching LOCK_CNT go to LOCKED, miss_cnt<=0.
  - Frame boundary, win!=SYNC_WORD: go to HUNT, hit_cnt<=0. No sync_miss pulse. The mismatching window is not re-examined that cycle.
  - Nibble boundaries produce no data_valid.
- LOCKED:
  - Nibble boundary: data_out<=win, nib_idx<=cur/4-1, data_valid pulse.
  - Frame boundary, hit: sync_hit pulse, miss_cnt<=0.
  - Frame boundary, miss: sync_miss pulse, miss_cnt+1. On reaching MISS_CNT go to HUNT (locked<=0, counters 0). Otherwise stay LOCKED and keep emitting payload at the flywheel positions.
  - Payload is emitted regardless of content, including windows equal to SYNC_WORD.
- locked rises one clock after the valid cycle that completes the lock, and falls one clock after the dropping miss.
- win containing X/Z while win_valid=0 is ignored.
- Reset mid-operation: immediate return to HUNT with outputs 0. After release, realignment from scratch (LOCK_CNT hits needed).

Test Plan (defaults: SYNC_WORD=0110, PAY_NIB=3, P=16; bench drives the bit stream through the shift-register model, win_valid=1):
- Stream frames [0110 1010 0101 1100] x3 after reset release -> sync_hit at end of 2nd sync, locked=1 next clock. Next frame gives data_valid pulses 4 clocks apart: data_out=A/nib_idx=0, 5/1, C/2. No data_valid before lock.
- Locked; 4th frame sync replaced with 0111 -> one sync_miss pulse, locked stays 1, payload A,5,C still emitted. 5th frame good sync -> sync_hit, miss_cnt cleared.
- Locked; two consecutive corrupted syncs (0000) -> sync_miss twice, locked=0 one clock after the 2nd miss, no further data_valid until relock two good frames later.
- From HUNT, stream 0110 followed by a bit stream whose window 16 bits later is 1001 -> CONFIRM aborts to HUNT, locked stays 0, no sync_miss or data_valid.
- Locked; win_valid low for 5 clocks mid-payload -> pos, data_out and nib_idx hold, no pulses. Sequence resumes (next nibble index unchanged) when win_valid returns.
- reset driven low between clock edges mid-frame while locked -> locked, data_out and data_valid go 0 without a clock edge. After release with a good stream, relock needs 2 syncs.
